// File: rtl/lsu.sv
// lsu -- load/store unit sitting directly in front of a word-addressed data RAM.
//
// It accepts byte, halfword and word loads and stores from the CPU memory
// stage over a valid/ready handshake and runs one request at a time. A store
// narrower than a word is done as read-modify-write: the RAM word is read, the
// target lanes are replaced, and the word is written back. Load data is taken
// from the addressed lane and zero- or sign-extended. A request with an illegal
// size, an address beyond the RAM, or (optionally) a misaligned address
// completes with resp_err and never touches the RAM.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses. Without it, misaligned low address bits are ignored.
//
// Parameters:
//   DATA_WIDTH  data width (lane logic is written for 32)
//   ADDR_WIDTH  CPU byte address width
//   BUS_WIDTH   RAM word-address width; the RAM covers 2^(BUS_WIDTH+2) bytes
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid / req_ready         request handshake
//   req_we, req_size, req_signed  store flag, size (00 b, 01 h, 10 w), sign-extend
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_err          load result / error flag; held until the next response
//   mem_re, mem_we, mem_addr      RAM read enable, write enable, word index
//   mem_wdata, mem_rdata          RAM write data, combinational read data
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  sgn;
        logic [BUS_WIDTH+1:0]  addr;   // only the bits that reach the RAM
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state;
    req_t                  rq;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    // ------------------------------------------------------------------
    // Accept-time checks, taken straight from the request inputs
    // ------------------------------------------------------------------
    logic out_of_range;
    logic misalign;
    logic bad_req;
    logic word_store;

    assign out_of_range = |(req_addr >> (BUS_WIDTH + 2));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_req    = (req_size == 2'b11) || out_of_range || misalign;
    assign word_store = req_we && (req_size == 2'b10);

    // ------------------------------------------------------------------
    // Load extract: lane select, then zero/sign fill
    // ------------------------------------------------------------------
    logic [1:0]            lane;
    logic                  half_sel;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_result;

    assign lane     = rq.addr[1:0];
    assign half_sel = rq.addr[1];
    assign ld_byte  = mem_rdata[{lane, 3'b000} +: 8];
    assign ld_half  = mem_rdata[{half_sel, 4'b0000} +: 16];

    always_comb begin
        ld_result = mem_rdata;
        case (rq.size)
            2'b00:   ld_result = {{(DATA_WIDTH-8){rq.sgn & ld_byte[7]}}, ld_byte};
            2'b01:   ld_result = {{(DATA_WIDTH-16){rq.sgn & ld_half[15]}}, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge: replicate the store data across lanes, then each byte
    // lane picks either the new data or the word read back from the RAM.
    // A word store has every lane enabled, so word_q is never consulted.
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]  lane_en;
    logic [DATA_WIDTH-1:0] st_rep;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        lane_en = '1;
        st_rep  = rq.wdata;
        case (rq.size)
            2'b00: begin
                lane_en = 4'b0001 << lane;
                st_rep  = {NUM_LANES{rq.wdata[7:0]}};
            end
            2'b01: begin
                lane_en = half_sel ? 4'b1100 : 4'b0011;
                st_rep  = {(NUM_LANES/2){rq.wdata[15:0]}};
            end
            default: begin
                lane_en = '1;
                st_rep  = rq.wdata;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign merged[8*g +: 8] = lane_en[g] ? st_rep[8*g +: 8] : word_q[8*g +: 8];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rq      <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rq.we    <= req_we;
                        rq.size  <= req_size;
                        rq.sgn   <= req_signed;
                        rq.addr  <= req_addr[BUS_WIDTH+1:0];
                        rq.wdata <= req_wdata;
                        if (bad_req) begin
                            // Result registers change only on entry to RESP,
                            // so they hold between responses.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= RESP;
                        end else if (word_store) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    word_q <= mem_rdata;
                    if (!rq.we) begin
                        rdata_q <= ld_result;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode from the state and are gated by rst_n so that a cycle
    // in which reset is asserted can never write the RAM or signal completion.
    assign req_ready  = rst_n && (state == IDLE);
    assign mem_re     = rst_n && (state == READ);
    assign mem_we     = rst_n && (state == WRITE);
    assign resp_valid = rst_n && (state == RESP);

    assign mem_addr   = (rst_n && (state != IDLE)) ? rq.addr[BUS_WIDTH+1:2] : '0;
    assign mem_wdata  = mem_we ? merged : '0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_re;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BUS_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT
    logic [31:0] ram [64];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    // Reference copy of the RAM, updated only by the model
    logic [31:0] mref [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what a request should return and how the RAM changes.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int nre, output int nwe);
        int unsigned idx, off, sh;
        logic [31:0] w, v, mask;
        err = (size == 2'd3) || (addr >= 32'd256);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) err = 1'b1;
`endif
        rdata = 32'd0; lat = 1; nre = 0; nwe = 0;
        if (err) return;
        idx = addr / 4;
        off = addr % 4;
        w   = mref[idx];
        sh  = (size == 2'd0) ? 8 * off : (size == 2'd1) ? 16 * (off / 2) : 0;
        if (!we) begin
            lat = 2; nre = 1;
            if (size == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (sgn && v >= 32'd128) v = v | 32'hFFFFFF00;
            end else if (size == 2'd1) begin
                v = (w >> sh) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            rdata = v;
        end else if (size == 2'd2) begin
            lat = 2; nwe = 1;
            mref[idx] = wdata;
        end else begin
            lat = 3; nre = 1; nwe = 1;
            mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            mref[idx] = (w & ~mask) | ((wdata << sh) & mask);
        end
    endtask

    // Issue one request and observe it until the response pulse.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nre, output int nwe);
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        nre = 0; nwe = 0; lat = 99; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_re) nre++;
            if (mem_we) begin
                nwe++;
                chk("write_addr", 32'(mem_addr), 32'(addr[7:2]));
            end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        if (lat == 99) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no resp_valid within 8 cycles of accept");
        end
        @(negedge clk);
        chk("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        chk("rdata_held", resp_rdata, rdata);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
    } vec_t;

    initial begin
        vec_t        vecs [$];
        logic [31:0] rd, m_rd, saved;
        logic        er, m_er;
        int          lat, nre, nwe, m_lat, m_re, m_we, seen;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
        end
        ram[0] = 32'hCAFEF00D;
        ram[1] = 32'h8899AABB;
        for (int i = 0; i < 64; i++) mref[i] = ram[i];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);

        // Directed vectors: we, size, sgn, addr, wdata, rdata, err, lat, #re, #we
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h6,   32'h0,        32'hFFFFFF99, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h6,   32'h0,        32'h00008899, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h6,   32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h5,   32'h0000005A, 32'h0,        1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'h88995ABB, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h8,   32'h12345678, 32'h0,        1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h8,   32'h0,        32'h12345678, 1'b0, 2, 1, 0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h3,   32'h0,        32'h0,        1'b1, 1, 0, 0});
`else
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h3,   32'h0,        32'h0000CAFE, 1'b0, 2, 1, 0});
`endif
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h4,   32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'hA,   32'h1234BEEF, 32'h0,        1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'hB,   32'h0,        32'h000000BE, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 0});

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, nre, nwe);
            model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                  m_rd, m_er, m_lat, m_re, m_we);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_mem_re_cycles", i), nre, vecs[i].exp_re);
            chk($sformatf("vec%0d_mem_we_cycles", i), nwe, vecs[i].exp_we);
        end
        chk("ram1_after_byte_store", ram[1], 32'h88995ABB);
        chk("ram2_after_half_store", ram[2], 32'hBEEF5678);

        // Reset landing on the WRITE cycle of a byte store to 0x5
        saved = ram[1];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h5; req_wdata = 32'h000000A5;
        @(posedge clk);                 // accept
        #1 req_valid = 1'b0;
        @(posedge clk);                 // into WRITE
        #1 rst_n = 1'b0;
        #1 chk("rst_write_mem_we", 32'(mem_we), 32'd0);
        chk("rst_write_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
            if (c == 0) chk("rst_abort_ready", 32'(req_ready), 32'd1);
        end
        chk("rst_abort_no_resp", seen, 0);
        chk("rst_abort_ram1", ram[1], saved);
        chk("rst_abort_resp_err_cleared", 32'(resp_err), 32'd0);

        // Randomised requests against the model
        for (int i = 0; i < 200; i++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_sgn   = 1'($urandom_range(0, 1));
            r_size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wdata, m_rd, m_er, m_lat, m_re, m_we);
            do_req(r_we, r_size, r_sgn, r_addr, r_wdata, rd, er, lat, nre, nwe);
            chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(m_er));
            chk($sformatf("rnd%0d_latency", i), lat, m_lat);
            chk($sformatf("rnd%0d_mem_re_cycles", i), nre, m_re);
            chk($sformatf("rnd%0d_mem_we_cycles", i), nwe, m_we);
        end

        for (int i = 0; i < 64; i++) begin
            chk($sformatf("final_ram%0d", i), ram[i], mref[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
